// File: rtl/elastic_buf_pkg.sv
// Shared sizing helpers for the elastic buffer family.
// Sibling buffers use the same width rules for pointers and occupancy counters.
package elastic_buf_pkg;

  // Pointer width for a power-of-two depth (never narrower than one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must be able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_buf_ptr.sv
// Wrapping storage pointer with increment enable and synchronous clear.
// Width is log2(DEPTH) so the pointer wraps from DEPTH-1 to 0 on its own.
module elastic_buf_ptr
  import elastic_buf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     inc,
  output logic [ptr_w(DEPTH)-1:0]  ptr
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [PTR_W-1:0] ptr_reg;

  // Pointer state: clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (clr) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= ptr_reg + PTR_W'(1);
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/elastic_buf.sv
// Valid/ready elastic FIFO with DEPTH entries, occupancy output and sync flush.
// ready_o depends only on registered state (plus flush/reset), never on ready_i.
// Optional macro ELASTIC_BUF_BYPASS_EN: when empty, an incoming beat is shown
// on the output in the same cycle and skips storage if taken immediately.
module elastic_buf
  import elastic_buf_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [DATA_LEN-1:0]      d_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [DATA_LEN-1:0]      d_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [cnt_w(DEPTH)-1:0]  count_o
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count_reg;
  logic [CNT_W-1:0]    count_next;
  logic                empty;
  logic                full;
  logic                pass;
  logic                push;
  logic                pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign ready_o = !full & !flush_i & rst_n;

`ifdef ELASTIC_BUF_BYPASS_EN
  // Empty buffer: the input beat is visible downstream combinationally.
  assign pass    = empty & valid_i & ready_i & !flush_i & rst_n;
  assign valid_o = empty ? (valid_i & !flush_i & rst_n) : !flush_i;
  assign d_o     = empty ? d_i : mem[rd_ptr];
`else
  assign pass    = 1'b0;
  assign valid_o = !empty & !flush_i;
  assign d_o     = mem[rd_ptr];
`endif

  // A bypassed beat is consumed directly and never enters storage.
  assign push = valid_i & ready_o & !pass;
  // Only stored beats advance the read side (flush already masks valid_o).
  assign pop  = !empty & valid_o & ready_i;

  elastic_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_i),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  elastic_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_i),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Occupancy next-state: flush empties, otherwise +1 push / -1 pop.
  always_comb begin
    count_next = count_reg;
    if (flush_i) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Occupancy register, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Storage write port; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= d_i;
    end
  end

  assign count_o = count_reg;

endmodule

// File: tb/tb_elastic_buf.sv
// Self-checking bench for elastic_buf (DEPTH=4) with a queue-based model.
module tb_elastic_buf;

  localparam int DEPTH = 4;
  localparam int DL    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic [DL-1:0] d_i;
  logic          valid_i;
  logic          ready_o;
  logic [DL-1:0] d_o;
  logic          valid_o;
  logic          ready_i;
  logic [2:0]    count_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  logic [31:0] popped[$];

  elastic_buf #(.DATA_LEN(DL), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .d_i     (d_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .d_o     (d_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model-based comparison every cycle, then advance the model for the edge.
  always @(negedge clk) begin
    int  n;
    bit  byp, er, ev, do_push, do_pop;
    if (!rst_n) begin
      q.delete();
      chk("m_rst_valid", {31'd0, valid_o}, 32'd0);
      chk("m_rst_ready", {31'd0, ready_o}, 32'd0);
      chk("m_rst_count", {29'd0, count_o}, 32'd0);
    end else begin
      n   = q.size();
      byp = 1'b0;
`ifdef ELASTIC_BUF_BYPASS_EN
      byp = (n == 0) && valid_i && !flush_i;
`endif
      er = (n != DEPTH) && !flush_i;
      ev = ((n != 0) || byp) && !flush_i;
      chk("m_ready", {31'd0, ready_o}, {31'd0, er});
      chk("m_valid", {31'd0, valid_o}, {31'd0, ev});
      chk("m_count", {29'd0, count_o}, 32'(n));
      if (ev) chk("m_data", d_o, (n != 0) ? q[0] : d_i);
      do_pop  = ev && ready_i;
      do_push = valid_i && er && !(byp && ready_i);
      if (do_pop) popped.push_back(d_o);
      if (do_pop && n != 0) void'(q.pop_front());
      if (do_push) q.push_back(d_i);
      if (flush_i) q.delete();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d);
    bit done;
    done    = 1'b0;
    valid_i = 1'b1;
    d_i     = d;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = ready_o;
      cyc();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=not_accepted required=accepted d=%h", d);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; d_i = '0; valid_i = 1'b0; ready_i = 1'b0;
    #3;
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_count", {29'd0, count_o}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, ready_o}, 32'd1);
    cyc();

    // Streaming with ready_i high: one beat per cycle, in order.
    ready_i = 1'b1;
    valid_i = 1'b1; d_i = 32'h11;
    @(negedge clk);
`ifdef ELASTIC_BUF_BYPASS_EN
    chk("stream_first_valid", {31'd0, valid_o}, 32'd1);
`else
    chk("stream_first_valid", {31'd0, valid_o}, 32'd0);
`endif
    cyc();
    for (int i = 1; i < 8; i++) send(32'((i + 1) * 32'h11));
    cyc(); cyc();
    chk("stream_cnt", 32'(popped.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("stream_order", popped[i], 32'((i + 1) * 32'h11));

    // Fill to full with ready_i low, fifth beat is held upstream.
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'hA0 + 32'(i));
    valid_i = 1'b1; d_i = 32'hA5;
    @(negedge clk);
    chk("full_ready", {31'd0, ready_o}, 32'd0);
    chk("full_count", {29'd0, count_o}, 32'd4);
    cyc();
    ready_i = 1'b1;
    @(negedge clk);
    chk("full_pop_count", {29'd0, count_o}, 32'd4);
    chk("full_pop_ready", {31'd0, ready_o}, 32'd0);
    chk("full_pop_data", d_o, 32'hA1);
    cyc();
    @(negedge clk);
    chk("after_pop_count", {29'd0, count_o}, 32'd3);
    chk("after_pop_ready", {31'd0, ready_o}, 32'd1);
    cyc();
    valid_i = 1'b0; ready_i = 1'b0;
    @(negedge clk);
    chk("hold3_count", {29'd0, count_o}, 32'd3);
    chk("hold3_data", d_o, 32'hA3);

    // Flush at count 3 with a beat offered.
    cyc();
    valid_i = 1'b1; d_i = 32'hF0; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    chk("flush_ready", {31'd0, ready_o}, 32'd0);
    cyc();
    valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("flush_count", {29'd0, count_o}, 32'd0);
    cyc();
    send(32'hC3);
    @(negedge clk);
    chk("post_flush_valid", {31'd0, valid_o}, 32'd1);
    chk("post_flush_data", d_o, 32'hC3);
    cyc();
    ready_i = 1'b1;
    cyc();
    ready_i = 1'b0;

    // Async reset mid-stream at count 2.
    send(32'hB1);
    send(32'hB2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, valid_o}, 32'd0);
    chk("async_ready", {31'd0, ready_o}, 32'd0);
    chk("async_count", {29'd0, count_o}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", {31'd0, ready_o}, 32'd1);
    chk("rel_valid", {31'd0, valid_o}, 32'd0);
    chk("rel_count", {29'd0, count_o}, 32'd0);
    cyc();

    // Empty buffer, beat offered with ready_i high.
    ready_i = 1'b1; valid_i = 1'b1; d_i = 32'hA5;
    @(negedge clk);
`ifdef ELASTIC_BUF_BYPASS_EN
    chk("byp_valid", {31'd0, valid_o}, 32'd1);
    chk("byp_data", d_o, 32'hA5);
    cyc();
    valid_i = 1'b0;
    @(negedge clk);
    chk("byp_count", {29'd0, count_o}, 32'd0);
    chk("byp_after_valid", {31'd0, valid_o}, 32'd0);
`else
    chk("nobyp_valid", {31'd0, valid_o}, 32'd0);
    cyc();
    valid_i = 1'b0;
    @(negedge clk);
    chk("nobyp_valid_next", {31'd0, valid_o}, 32'd1);
    chk("nobyp_data_next", d_o, 32'hA5);
    chk("nobyp_count_next", {29'd0, count_o}, 32'd1);
`endif
    cyc(); cyc();
    ready_i = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
